// File: rtl/mod12_counter_checker_if.sv
// Signal bundle between the mod-12 counter stimulus/observation points and the checker.
interface mod12_counter_checker_if;
  localparam int unsigned VAL_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ST_W  = 2;

  logic             dut_rst;
  logic             load_in;
  logic [VAL_W-1:0] data_in;
  logic             up_down;
  logic [VAL_W-1:0] data_out;

  logic [VAL_W-1:0] exp_out;
  logic [ST_W-1:0]  state;
  logic             mismatch;
  logic             illegal_load;
  logic             err_flag;
  logic [CNT_W-1:0] err_count;
  logic [VAL_W-1:0] first_exp;
  logic [VAL_W-1:0] first_obs;

  modport master (
    output dut_rst, load_in, data_in, up_down, data_out,
    input  exp_out, state, mismatch, illegal_load, err_flag, err_count, first_exp, first_obs
  );

  modport slave (
    input  dut_rst, load_in, data_in, up_down, data_out,
    output exp_out, state, mismatch, illegal_load, err_flag, err_count, first_exp, first_obs
  );
endinterface

// File: rtl/mod12_counter_checker.sv
// Passive reference-model checker for a mod-12 loadable up/down counter; flags,
// counts and captures divergences, halting after MAX_ERR errors.
module mod12_counter_checker #(
  parameter int unsigned MAX_ERR = 16
) (
  input logic                     clock,
  input logic                     rst,
  mod12_counter_checker_if.slave  bus
);
  localparam int unsigned VAL_W   = 4;
  localparam int unsigned CNT_W   = 8;
  localparam logic [VAL_W-1:0] TOP_VAL = VAL_W'(11);

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    CHECK = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [VAL_W-1:0] exp_q, exp_d;
  logic             mismatch_q, mismatch_d;
  logic             illegal_q, illegal_d;
  logic             err_flag_q, err_flag_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [VAL_W-1:0] first_exp_q, first_exp_d;
  logic [VAL_W-1:0] first_obs_q, first_obs_d;

  logic             mism_c;
  logic [VAL_W-1:0] cur_c;

  // Wrap decided by explicit compares, never by 4-bit overflow.
  function automatic logic [VAL_W-1:0] step(input logic [VAL_W-1:0] v, input logic up);
    if (up) return (v == TOP_VAL)      ? VAL_W'(0) : v + VAL_W'(1);
    else    return (v == VAL_W'(0))    ? TOP_VAL   : v - VAL_W'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= SEEK;
      exp_q       <= '0;
      mismatch_q  <= 1'b0;
      illegal_q   <= 1'b0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
      first_exp_q <= '0;
      first_obs_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      mismatch_q  <= mismatch_d;
      illegal_q   <= illegal_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
      first_exp_q <= first_exp_d;
      first_obs_q <= first_obs_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    mismatch_d  = 1'b0;
    illegal_d   = 1'b0;
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    first_exp_d = first_exp_q;
    first_obs_d = first_obs_q;
    mism_c      = 1'b0;
    cur_c       = exp_q;

    if (state_q != HALT) begin
      mism_c = (state_q == CHECK) && (bus.data_out != exp_q);
      // On a mismatch the model resyncs to the observed value so one fault costs one error.
      cur_c  = mism_c ? bus.data_out : exp_q;

      if (bus.dut_rst) begin
        exp_d   = '0;
        state_d = CHECK;
      end else if (bus.load_in) begin
        if (bus.data_in <= TOP_VAL) begin
          exp_d   = bus.data_in;
          state_d = CHECK;
        end else begin
          illegal_d = 1'b1;
          state_d   = SEEK;
        end
      end else if (state_q == CHECK) begin
        if (cur_c > TOP_VAL) state_d = SEEK;
        else                 exp_d   = step(cur_c, bus.up_down);
      end

      if (mism_c) begin
        mismatch_d  = 1'b1;
        err_count_d = err_count_q + CNT_W'(1);
        if (!err_flag_q) begin
          err_flag_d  = 1'b1;
          first_exp_d = exp_q;
          first_obs_d = bus.data_out;
        end
        if (err_count_d == CNT_W'(MAX_ERR)) state_d = HALT;
      end
    end
  end

  assign bus.exp_out      = exp_q;
  assign bus.state        = state_q;
  assign bus.mismatch     = mismatch_q;
  assign bus.illegal_load = illegal_q;
  assign bus.err_flag     = err_flag_q;
  assign bus.err_count    = err_count_q;
  assign bus.first_exp    = first_exp_q;
  assign bus.first_obs    = first_obs_q;
endmodule
